// File: rtl/aes_block_packer.sv
// Byte-stream packer for aescipher: assembles 128-bit big-endian blocks, applies
// PKCS#7 padding at message end and queues finished blocks in a small FIFO.
module aes_block_packer #(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [7:0]   in_byte,
   input  logic         in_valid,
   input  logic         in_last,
   output logic         in_ready,
   output logic [127:0] blk_data,
   output logic         blk_valid,
   input  logic         blk_ready,
   output logic         blk_pad,
   output logic         blk_last
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic [0:0] {COLLECT = 1'b0, PADBLK = 1'b1} state_t;

   state_t          state_r, state_n;
   logic [3:0]      idx_r, idx_n;
   logic [127:0]    asm_r, asm_n;
   logic [127:0]    mem_data_r [DEPTH];
   logic            mem_pad_r  [DEPTH];
   logic            mem_last_r [DEPTH];
   logic [PW-1:0]   wr_ptr_r, wr_ptr_n, rd_ptr_r, rd_ptr_n;
   logic [CW-1:0]   count_r, count_n;
   logic            in_ready_r, in_ready_n;
   logic            blk_valid_r, blk_valid_n;
   logic [127:0]    blk_data_r, blk_data_n;
   logic            blk_pad_r, blk_pad_n;
   logic            blk_last_r, blk_last_n;

   logic            accept_s, pop_s, push_s, push_pad_s, push_last_s;
   logic [127:0]    push_data_s, merged_s, padded_s;
   logic [7:0]      pad_val_s;

   assign in_ready  = in_ready_r;
   assign blk_valid = blk_valid_r;
   assign blk_data  = blk_data_r;
   assign blk_pad   = blk_pad_r;
   assign blk_last  = blk_last_r;

   // Next-state: byte assembly, padding, push/pop bookkeeping and next head entry.
   always_comb begin
      accept_s  = in_valid && in_ready_r;
      pop_s     = blk_valid_r && blk_ready;
      pad_val_s = 8'd15 - {4'd0, idx_r};
      merged_s  = asm_r;
      padded_s  = asm_r;
      // Bytes past the current index become the pad value when the message ends here.
      for (int j = 0; j < 16; j++) begin
         merged_s[127-8*j -: 8] = (4'(j) == idx_r) ? in_byte : asm_r[127-8*j -: 8];
         padded_s[127-8*j -: 8] = (4'(j) == idx_r) ? in_byte :
                                  (4'(j) >  idx_r) ? pad_val_s : asm_r[127-8*j -: 8];
      end
      push_s      = 1'b0;
      push_data_s = 128'd0;
      push_pad_s  = 1'b0;
      push_last_s = 1'b0;
      state_n     = state_r;
      idx_n       = idx_r;
      asm_n       = asm_r;
      case (state_r)
         COLLECT: begin
            if (accept_s) begin
               if (in_last && (idx_r != 4'd15)) begin
                  push_s      = 1'b1;
                  push_data_s = padded_s;
                  push_pad_s  = 1'b1;
                  push_last_s = 1'b1;
                  idx_n       = 4'd0;
                  asm_n       = 128'd0;
               end else if (idx_r == 4'd15) begin
                  push_s      = 1'b1;
                  push_data_s = merged_s;
                  idx_n       = 4'd0;
                  asm_n       = 128'd0;
                  state_n     = in_last ? PADBLK : COLLECT;
               end else begin
                  asm_n = merged_s;
                  idx_n = idx_r + 4'd1;
               end
            end else begin
               state_n = COLLECT;
            end
         end
         PADBLK: begin
            if (count_r < CW'(DEPTH)) begin
               push_s      = 1'b1;
               push_data_s = {16{8'h10}};
               push_pad_s  = 1'b1;
               push_last_s = 1'b1;
               state_n     = COLLECT;
            end else begin
               state_n = PADBLK;
            end
         end
         default: begin
            state_n = COLLECT;
            idx_n   = 4'd0;
            asm_n   = 128'd0;
         end
      endcase

      count_n  = count_r + CW'(push_s) - CW'(pop_s);
      wr_ptr_n = wr_ptr_r + PW'(push_s);
      rd_ptr_n = rd_ptr_r + PW'(pop_s);

      // When nothing older survives this cycle, the block being pushed becomes the head.
      if (count_n == CW'(0)) begin
         blk_valid_n = 1'b0;
         blk_data_n  = 128'd0;
         blk_pad_n   = 1'b0;
         blk_last_n  = 1'b0;
      end else if (push_s && (count_r == CW'(pop_s))) begin
         blk_valid_n = 1'b1;
         blk_data_n  = push_data_s;
         blk_pad_n   = push_pad_s;
         blk_last_n  = push_last_s;
      end else begin
         blk_valid_n = 1'b1;
         blk_data_n  = mem_data_r[rd_ptr_n];
         blk_pad_n   = mem_pad_r[rd_ptr_n];
         blk_last_n  = mem_last_r[rd_ptr_n];
      end
      in_ready_n = (state_n == COLLECT) && (count_n < CW'(DEPTH));
   end

   // State, FIFO storage and registered output head.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= COLLECT;
         idx_r       <= 4'd0;
         asm_r       <= 128'd0;
         wr_ptr_r    <= '0;
         rd_ptr_r    <= '0;
         count_r     <= '0;
         in_ready_r  <= 1'b1;
         blk_valid_r <= 1'b0;
         blk_data_r  <= 128'd0;
         blk_pad_r   <= 1'b0;
         blk_last_r  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_data_r[i] <= 128'd0;
            mem_pad_r[i]  <= 1'b0;
            mem_last_r[i] <= 1'b0;
         end
      end else begin
         state_r     <= state_n;
         idx_r       <= idx_n;
         asm_r       <= asm_n;
         wr_ptr_r    <= wr_ptr_n;
         rd_ptr_r    <= rd_ptr_n;
         count_r     <= count_n;
         in_ready_r  <= in_ready_n;
         blk_valid_r <= blk_valid_n;
         blk_data_r  <= blk_data_n;
         blk_pad_r   <= blk_pad_n;
         blk_last_r  <= blk_last_n;
         if (push_s) begin
            mem_data_r[wr_ptr_r] <= push_data_s;
            mem_pad_r[wr_ptr_r]  <= push_pad_s;
            mem_last_r[wr_ptr_r] <= push_last_s;
         end
      end
   end
endmodule

// File: tb/tb_aes_block_packer.sv
// Scoreboard bench for aes_block_packer: directed byte streams, expected blocks
// queued at stimulus time and compared by an independent output monitor.
module tb_aes_block_packer;
   logic         clk = 1'b0;
   logic         rst;
   logic [7:0]   in_byte;
   logic         in_valid;
   logic         in_last;
   logic         in_ready;
   logic [127:0] blk_data;
   logic         blk_valid;
   logic         blk_ready;
   logic         blk_pad;
   logic         blk_last;

   typedef struct packed {
      logic [127:0] data;
      logic         pad;
      logic         last;
   } blk_t;

   blk_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   aes_block_packer #(.DEPTH(2)) dut (
      .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid),
      .in_last(in_last), .in_ready(in_ready), .blk_data(blk_data),
      .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_pad(blk_pad),
      .blk_last(blk_last)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic expect_blk(input logic [127:0] d, input logic p, input logic l);
      blk_t b;
      b.data = d;
      b.pad  = p;
      b.last = l;
      exp_q.push_back(b);
   endtask

   // Monitor: every pop is compared against the oldest expected block.
   always @(negedge clk) begin
      if (!rst && blk_valid && blk_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_block", blk_data, 128'd0);
            if (blk_data == 128'd0) begin
               errors++;
               $display("FAIL unexpected_block actual=%h required=none", blk_data);
            end
         end else begin
            blk_t e;
            e = exp_q.pop_front();
            chk("blk_data", blk_data, e.data);
            chk("blk_pad", {127'd0, blk_pad}, {127'd0, e.pad});
            chk("blk_last", {127'd0, blk_last}, {127'd0, e.last});
         end
      end
   end

   // Returns one cycle after the byte is accepted (posedge + 1).
   task automatic send_byte(input logic [7:0] b, input logic l);
      int waited = 0;
      in_byte  = b;
      in_last  = l;
      in_valid = 1'b1;
      while (!in_ready && waited < 1000) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!in_ready) chk("in_ready_timeout", {127'd0, in_ready}, 128'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_block(input logic [127:0] d, input int n, input logic l);
      logic [127:0] v;
      v = d;
      for (int i = 0; i < n; i++)
         send_byte(v[127-8*i -: 8], l && (i == n - 1));
   endtask

   task automatic drain;
      int waited = 0;
      while (exp_q.size() != 0 && waited < 200) begin
         @(posedge clk); #1;
         waited++;
      end
      chk("drain_queue_empty", 128'(exp_q.size()), 128'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [127:0] a_blk, b_blk, v;
      a_blk = 128'h00112233445566778899aabbccddeeff;
      b_blk = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
      rst = 1'b1; in_byte = 8'd0; in_valid = 1'b0; in_last = 1'b0; blk_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_blk_valid", {127'd0, blk_valid}, 128'd0);
      chk("rst_blk_data", blk_data, 128'd0);
      chk("rst_blk_pad_last", {126'd0, blk_pad, blk_last}, 128'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      chk("in_ready_after_rst", {127'd0, in_ready}, 128'd1);

      // Hello World!: 12 bytes, four 0x04 pad bytes.
      blk_ready = 1'b1;
      send_block(128'h48656c6c6f20576f726c642100000000, 11, 1'b0);
      chk("hello_not_valid_early", {127'd0, blk_valid}, 128'd0);
      expect_blk(128'h48656c6c6f20576f726c642104040404, 1'b1, 1'b1);
      send_byte(8'h21, 1'b1);
      chk("hello_valid_latency", {127'd0, blk_valid}, 128'd1);
      drain();

      // Full 16-byte message followed by a whole pad block.
      expect_blk(128'h5468617473206d79204b756e67204675, 1'b0, 1'b0);
      expect_blk({16{8'h10}}, 1'b1, 1'b1);
      send_block(128'h5468617473206d79204b756e67204675, 16, 1'b1);
      chk("padblk_in_ready_low", {127'd0, in_ready}, 128'd0);
      drain();

      // Single byte message.
      expect_blk(128'h410f0f0f0f0f0f0f0f0f0f0f0f0f0f0f, 1'b1, 1'b1);
      send_byte(8'h41, 1'b1);
      drain();

      // Backpressure: FIFO fills after 32 bytes, head holds stable.
      blk_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 16; i++) v[127-8*i -: 8] = 8'(16*k + i);
         expect_blk(v, 1'b0, 1'b0);
      end
      for (int i = 0; i < 32; i++) send_byte(8'(i), 1'b0);
      chk("full_in_ready_low", {127'd0, in_ready}, 128'd0);
      chk("full_head", blk_data, 128'h000102030405060708090a0b0c0d0e0f);
      repeat (3) @(posedge clk);
      #1;
      chk("full_head_stable", blk_data, 128'h000102030405060708090a0b0c0d0e0f);
      chk("full_in_ready_still_low", {127'd0, in_ready}, 128'd0);
      blk_ready = 1'b1;
      @(posedge clk); #1;
      chk("in_ready_after_pop", {127'd0, in_ready}, 128'd1);
      for (int i = 32; i < 48; i++) send_byte(8'(i), 1'b0);
      drain();

      // Simultaneous push and pop with one block queued.
      blk_ready = 1'b0;
      expect_blk(a_blk, 1'b0, 1'b0);
      send_block(a_blk, 16, 1'b0);
      send_block(b_blk, 15, 1'b0);
      expect_blk(b_blk, 1'b0, 1'b0);
      in_byte = 8'h0f; in_last = 1'b0; in_valid = 1'b1; blk_ready = 1'b1;
      chk("pushpop_in_ready", {127'd0, in_ready}, 128'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("pushpop_valid", {127'd0, blk_valid}, 128'd1);
      chk("pushpop_head", blk_data, b_blk);
      chk("pushpop_in_ready_after", {127'd0, in_ready}, 128'd1);
      drain();

      // Reset with one block queued and a partial block assembled.
      blk_ready = 1'b0;
      send_block(a_blk, 16, 1'b0);
      send_block(b_blk, 7, 1'b0);
      chk("pre_reset_valid", {127'd0, blk_valid}, 128'd1);
      #2; rst = 1'b1;
      #1;
      chk("async_reset_valid", {127'd0, blk_valid}, 128'd0);
      chk("async_reset_data", blk_data, 128'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      chk("post_reset_empty", {127'd0, blk_valid}, 128'd0);
      blk_ready = 1'b1;
      expect_blk(128'haa0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f, 1'b1, 1'b1);
      send_byte(8'haa, 1'b1);
      drain();
      repeat (3) @(posedge clk);
      #1;
      chk("final_idle", {127'd0, blk_valid}, 128'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
